// File: rtl/instr_boot_loader.sv
// Byte-stream program loader: assembles 19-bit instruction words, writes them to
// instruction memory and releases the core only after a verified checksum.
module instr_boot_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [18:0] BASE_ADDR = 19'd0,
    parameter int          ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [18:0] imem_addr,
    output logic [18:0] imem_wd,
    output logic        core_rst_n,
    output logic        boot_done,
    output logic        boot_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_W0,
        S_W1,
        S_W2,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt_hi;
    logic [15:0] word_total;
    logic [15:0] word_cnt;
    logic [2:0]  byte0_lo;
    logic [7:0]  byte1;
    logic [7:0]  sum;
    logic        xfer;

    assign xfer = rx_valid && rx_ready;

    // Next-state decode; rx_ready and imem_we are pure functions of the state.
    always_comb begin
        next_state = state;
        rx_ready   = 1'b0;
        imem_we    = 1'b0;
        case (state)
            S_IDLE: next_state = S_CNT_HI;
            S_CNT_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) next_state = S_CNT_LO;
            end
            S_CNT_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, cnt_hi, rx_data} > 17'(DEPTH))
                        next_state = S_ERR;
                    else if ({cnt_hi, rx_data} == 16'd0)
                        next_state = S_CSUM;
                    else
                        next_state = S_W0;
                end
            end
            S_W0: begin
                rx_ready = 1'b1;
                if (rx_valid) next_state = (rx_data[7:3] != 5'd0) ? S_ERR : S_W1;
            end
            S_W1: begin
                rx_ready = 1'b1;
                if (rx_valid) next_state = S_W2;
            end
            S_W2: begin
                rx_ready = 1'b1;
                if (rx_valid) next_state = S_WRITE;
            end
            S_WRITE: begin
                imem_we    = 1'b1;
                next_state = (word_cnt + 16'd1 == word_total) ? S_CSUM : S_W0;
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) next_state = (rx_data == sum) ? S_DONE : S_ERR;
            end
            S_DONE:  next_state = S_DONE;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_IDLE;
        endcase
    end

    // State register plus the datapath registers loaded on each accepted byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt_hi     <= 8'd0;
            word_total <= 16'd0;
            word_cnt   <= 16'd0;
            byte0_lo   <= 3'd0;
            byte1      <= 8'd0;
            sum        <= 8'd0;
            imem_addr  <= BASE_ADDR;
            imem_wd    <= 19'd0;
            core_rst_n <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            state <= next_state;
            // The checksum byte itself is excluded from the running sum.
            if (xfer && state != S_CSUM) sum <= sum + rx_data;
            case (state)
                S_CNT_HI: if (xfer) cnt_hi <= rx_data;
                S_CNT_LO: begin
                    if (xfer) word_total <= {cnt_hi, rx_data};
                    word_cnt <= 16'd0;
                end
                S_W0: if (xfer) byte0_lo <= rx_data[2:0];
                S_W1: if (xfer) byte1 <= rx_data;
                S_W2: if (xfer) imem_wd <= {byte0_lo, byte1, rx_data};
                S_WRITE: begin
                    imem_addr <= imem_addr + 19'(ADDR_STEP);
                    word_cnt  <= word_cnt + 16'd1;
                end
                S_DONE: begin
                    core_rst_n <= 1'b1;
                    boot_done  <= 1'b1;
                end
                S_ERR: boot_err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_boot_loader.sv
// Scoreboard bench for instr_boot_loader: expected memory writes are queued as
// bytes are streamed and popped when imem_we is observed.
module tb_instr_boot_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [18:0] imem_addr;
    logic [18:0] imem_wd;
    logic        core_rst_n;
    logic        boot_done;
    logic        boot_err;

    logic [37:0] exp_q[$];
    int          pass_cnt;
    int          total_cnt;

    instr_boot_loader #(
        .DEPTH(1024),
        .BASE_ADDR(19'd0),
        .ADDR_STEP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wd(imem_wd),
        .core_rst_n(core_rst_n),
        .boot_done(boot_done),
        .boot_err(boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Every write the DUT issues must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", {13'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                checkOutput("write_addr", {13'd0, imem_addr}, {13'd0, e[37:19]});
                checkOutput("write_data", {13'd0, imem_wd}, {13'd0, e[18:0]});
            end
        end
    end

    task automatic expectWrite(input logic [18:0] addr, input logic [18:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic applyReset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rx_ready",   {31'd0, rx_ready},   32'd0);
        checkOutput("rst_imem_we",    {31'd0, imem_we},    32'd0);
        checkOutput("rst_imem_addr",  {13'd0, imem_addr},  32'd0);
        checkOutput("rst_imem_wd",    {13'd0, imem_wd},    32'd0);
        checkOutput("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        checkOutput("rst_boot_done",  {31'd0, boot_done},  32'd0);
        checkOutput("rst_boot_err",   {31'd0, boot_err},   32'd0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Offers one byte from a negedge and returns at the negedge after the handshake.
    task automatic applyStimulus(input logic [7:0] b, input bit stall);
        int waited;
        waited = 0;
        if (stall) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            checkOutput("handshake_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic sendStream(input byte_q_t s, input bit stall);
        foreach (s[i]) applyStimulus(s[i], stall);
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err, input logic crst);
        checkOutput({tag, "_boot_done"},  {31'd0, boot_done},  {31'd0, done});
        checkOutput({tag, "_boot_err"},   {31'd0, boot_err},   {31'd0, err});
        checkOutput({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, crst});
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_writes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    byte_q_t nominal;
    byte_q_t bad_sum;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        nominal   = '{8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h07, 8'hFF, 8'hFF, 8'h4D};
        bad_sum   = '{8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h07, 8'hFF, 8'hFF, 8'h4E};

        // Nominal two-word image at full rate
        applyReset();
        expectWrite(19'd0, 19'h01234);
        expectWrite(19'd4, 19'h7FFFF);
        sendStream(nominal, 1'b0);
        @(negedge clk);
        checkStatus("nominal", 1'b1, 1'b0, 1'b1);
        checkOutput("nominal_next_addr", {13'd0, imem_addr}, 32'd8);
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("nominal_ready_after_done", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
        checkDrained("nominal");

        // Wrong checksum: both words still written, then terminal error
        applyReset();
        expectWrite(19'd0, 19'h01234);
        expectWrite(19'd4, 19'h7FFFF);
        sendStream(bad_sum, 1'b0);
        @(negedge clk);
        checkStatus("badsum", 1'b0, 1'b1, 1'b0);
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("badsum_ready_after_err", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
        checkDrained("badsum");

        // Empty image
        applyReset();
        sendStream('{8'h00, 8'h00, 8'h00}, 1'b0);
        @(negedge clk);
        checkStatus("empty", 1'b1, 1'b0, 1'b1);
        checkDrained("empty");

        // Oversized count 0x0401 > DEPTH
        applyReset();
        sendStream('{8'h04, 8'h01}, 1'b0);
        @(negedge clk);
        checkStatus("oversize", 1'b0, 1'b1, 1'b0);
        checkOutput("oversize_ready", {31'd0, rx_ready}, 32'd0);
        repeat (5) @(negedge clk);
        checkDrained("oversize");

        // Count of DEPTH exactly is accepted (boundary)
        applyReset();
        sendStream('{8'h04, 8'h00}, 1'b0);
        checkOutput("depth_edge_ready", {31'd0, rx_ready}, 32'd1);
        checkOutput("depth_edge_no_err", {31'd0, boot_err}, 32'd0);

        // Nonzero byte0[7:3] is a format error with no write
        applyReset();
        sendStream('{8'h00, 8'h01, 8'h08}, 1'b0);
        @(negedge clk);
        checkStatus("format", 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkDrained("format");

        // Nominal image with random valid gaps
        applyReset();
        expectWrite(19'd0, 19'h01234);
        expectWrite(19'd4, 19'h7FFFF);
        sendStream(nominal, 1'b1);
        @(negedge clk);
        checkStatus("stall", 1'b1, 1'b0, 1'b1);
        checkDrained("stall");

        // Reset in the middle of a load, then a clean reload
        applyReset();
        expectWrite(19'd0, 19'h01234);
        sendStream('{8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h07}, 1'b0);
        repeat (2) @(negedge clk);
        checkDrained("midload_partial");
        applyReset();
        expectWrite(19'd0, 19'h01234);
        expectWrite(19'd4, 19'h7FFFF);
        sendStream(nominal, 1'b0);
        @(negedge clk);
        checkStatus("reload", 1'b1, 1'b0, 1'b1);
        checkDrained("reload");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
